// File: rtl/input_write_packer.sv
// Write-side front end for a double buffer. Packs COUNT narrow elements per word,
// writes the words into the current write bank, then requests a bank swap once the
// fill is complete and the consumer has released the read bank.
module input_write_packer #(
  parameter int unsigned IN_WIDTH        = 16,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned COUNT           = 4,
  parameter int unsigned BANK_ADDR_WIDTH = 7,
  parameter int unsigned BANK_DEPTH      = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       config_en,
  input  logic [BANK_ADDR_WIDTH:0]   config_words,
  input  logic [IN_WIDTH-1:0]        in_data,
  input  logic                       in_vld,
  output logic                       in_rdy,
  output logic                       wen,
  output logic [BANK_ADDR_WIDTH-1:0] wadr,
  output logic [DATA_WIDTH-1:0]      wdata,
  output logic                       switch_banks,
  output logic                       rd_valid,
  input  logic                       read_done
);

  localparam int unsigned ElemW = $clog2(COUNT);
  localparam int unsigned CntW  = BANK_ADDR_WIDTH + 1;

  localparam logic [CntW-1:0]  DepthW   = CntW'(BANK_DEPTH);
  localparam logic [ElemW-1:0] LastLane = ElemW'(COUNT - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StFill     = 3'd1;
  localparam logic [2:0] StDrain    = 3'd2;
  localparam logic [2:0] StWaitSwap = 3'd3;
  localparam logic [2:0] StSwap     = 3'd4;

  logic [2:0]                 state_q, state_d;
  logic [ElemW-1:0]           elem_cnt_q, elem_cnt_d;
  logic [CntW-1:0]            word_cnt_q, word_cnt_d;
  logic [CntW-1:0]            cfg_words_q, cfg_words_d;
  logic [DATA_WIDTH-1:0]      pack_q, pack_d;
  logic                       in_rdy_q, in_rdy_d;
  logic                       wen_q, wen_d;
  logic [BANK_ADDR_WIDTH-1:0] wadr_q, wadr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       switch_q, switch_d;
  logic                       rd_valid_q, rd_valid_d;

  logic                       accept;
  logic [CntW-1:0]            cfg_clamped;

  assign accept      = in_vld && in_rdy_q && (state_q == StFill);
  assign cfg_clamped = (config_words > DepthW) ? DepthW : config_words;

  // Next-state logic: config_en overrides everything else in the same cycle.
  always_comb begin
    state_d     = state_q;
    elem_cnt_d  = elem_cnt_q;
    word_cnt_d  = word_cnt_q;
    cfg_words_d = cfg_words_q;
    pack_d      = pack_q;
    in_rdy_d    = in_rdy_q;
    wen_d       = 1'b0;
    wadr_d      = wadr_q;
    wdata_d     = wdata_q;
    switch_d    = 1'b0;
    rd_valid_d  = rd_valid_q;

    // A release during SWAP refers to the bank that is about to become the write bank.
    if (rd_valid_q && read_done && (state_q != StSwap)) begin
      rd_valid_d = 1'b0;
    end

    if (config_en) begin
      cfg_words_d = cfg_clamped;
      elem_cnt_d  = '0;
      word_cnt_d  = '0;
      pack_d      = '0;
      rd_valid_d  = 1'b0;
      if (config_words == '0) begin
        state_d  = StIdle;
        in_rdy_d = 1'b0;
      end else begin
        state_d  = StFill;
        in_rdy_d = 1'b1;
      end
    end else begin
      case (state_q)
        StIdle: begin
          in_rdy_d = 1'b0;
        end
        StFill: begin
          if (accept) begin
            pack_d[int'(elem_cnt_q) * IN_WIDTH +: IN_WIDTH] = in_data;
            if (elem_cnt_q == LastLane) begin
              wen_d      = 1'b1;
              wadr_d     = word_cnt_q[BANK_ADDR_WIDTH-1:0];
              wdata_d    = pack_d;
              elem_cnt_d = '0;
              word_cnt_d = word_cnt_q + CntW'(1);
              if (word_cnt_q == cfg_words_q - CntW'(1)) begin
                in_rdy_d = 1'b0;
                state_d  = StDrain;
              end
            end else begin
              elem_cnt_d = elem_cnt_q + ElemW'(1);
            end
          end
        end
        StDrain: begin
          // Final write is on the bus this cycle; swap only afterwards.
          state_d = StWaitSwap;
        end
        StWaitSwap: begin
          if (!rd_valid_q) begin
            state_d  = StSwap;
            switch_d = 1'b1;
          end
        end
        StSwap: begin
          rd_valid_d = 1'b1;
          word_cnt_d = '0;
          elem_cnt_d = '0;
          in_rdy_d   = 1'b1;
          state_d    = StFill;
        end
        default: begin
          state_d  = StIdle;
          in_rdy_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      elem_cnt_q  <= '0;
      word_cnt_q  <= '0;
      cfg_words_q <= '0;
      pack_q      <= '0;
      in_rdy_q    <= 1'b0;
      wen_q       <= 1'b0;
      wadr_q      <= '0;
      wdata_q     <= '0;
      switch_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      elem_cnt_q  <= elem_cnt_d;
      word_cnt_q  <= word_cnt_d;
      cfg_words_q <= cfg_words_d;
      pack_q      <= pack_d;
      in_rdy_q    <= in_rdy_d;
      wen_q       <= wen_d;
      wadr_q      <= wadr_d;
      wdata_q     <= wdata_d;
      switch_q    <= switch_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign in_rdy       = in_rdy_q;
  assign wen          = wen_q;
  assign wadr         = wadr_q;
  assign wdata        = wdata_q;
  assign switch_banks = switch_q;
  assign rd_valid     = rd_valid_q;

endmodule
